// File: rtl/ycbcr_to_rgb.sv
// Full-range BT.601 YCbCr -> RGB converter, three-stage pipeline with Q8 coefficients.
// The whole pipeline holds on a global stall (output valid but not accepted).
module ycbcr_to_rgb #(
  parameter logic [8:0] C_RCR = 9'd359,
  parameter logic [8:0] C_GCB = 9'd88,
  parameter logic [8:0] C_GCR = 9'd183,
  parameter logic [8:0] C_BCB = 9'd454
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [23:0] in_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [23:0] out_data
);

  localparam logic signed [19:0] K_RCR = $signed({11'd0, C_RCR});
  localparam logic signed [19:0] K_GCB = $signed({11'd0, C_GCB});
  localparam logic signed [19:0] K_GCR = $signed({11'd0, C_GCR});
  localparam logic signed [19:0] K_BCB = $signed({11'd0, C_BCB});

  logic               stall_s;
  logic               v1_r;
  logic        [7:0]  y1_r;
  logic signed [8:0]  cb1_r;
  logic signed [8:0]  cr1_r;
  logic               v2_r;
  logic        [15:0] y2_r;
  logic signed [19:0] pr_r;
  logic signed [19:0] pgb_r;
  logic signed [19:0] pgr_r;
  logic signed [19:0] pb_r;
  logic signed [19:0] cb_ext_s;
  logic signed [19:0] cr_ext_s;
  logic signed [19:0] y_ext_s;
  logic signed [19:0] sr_s;
  logic signed [19:0] sg_s;
  logic signed [19:0] sb_s;
  logic        [23:0] rgb_s;

  // Floor (arithmetic shift) of a rounded Q8 sum, then saturate to 0..255.
  function automatic logic [7:0] clamp8(input logic signed [19:0] s);
    logic signed [19:0] q;
    q = s >>> 8;
    if (q < 20'sd0) begin
      clamp8 = 8'd0;
    end else if (q > 20'sd255) begin
      clamp8 = 8'd255;
    end else begin
      clamp8 = q[7:0];
    end
  endfunction

  assign stall_s  = out_valid & ~out_ready;
  assign in_ready = ~stall_s;

  // Stage 1: capture Y and re-centre the chroma samples around zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      v1_r  <= 1'b0;
      y1_r  <= 8'd0;
      cb1_r <= 9'sd0;
      cr1_r <= 9'sd0;
    end else if (!stall_s) begin
      v1_r <= in_valid;
      if (in_valid) begin
        y1_r  <= in_data[23:16];
        cb1_r <= $signed({1'b0, in_data[15:8]} - 9'd128);
        cr1_r <= $signed({1'b0, in_data[7:0]} - 9'd128);
      end
    end
  end

  // Sign-extend chroma so the products are formed at full 20-bit width.
  always_comb begin
    cb_ext_s = $signed({{11{cb1_r[8]}}, cb1_r});
    cr_ext_s = $signed({{11{cr1_r[8]}}, cr1_r});
  end

  // Stage 2: coefficient products and Y scaled into Q8.
  always_ff @(posedge clk) begin
    if (rst) begin
      v2_r  <= 1'b0;
      y2_r  <= 16'd0;
      pr_r  <= 20'sd0;
      pgb_r <= 20'sd0;
      pgr_r <= 20'sd0;
      pb_r  <= 20'sd0;
    end else if (!stall_s) begin
      v2_r <= v1_r;
      if (v1_r) begin
        y2_r  <= {y1_r, 8'd0};
        pr_r  <= K_RCR * cr_ext_s;
        pgb_r <= K_GCB * cb_ext_s;
        pgr_r <= K_GCR * cr_ext_s;
        pb_r  <= K_BCB * cb_ext_s;
      end
    end
  end

  // Stage 3 combinational part: rounded sums and per-channel clamp.
  always_comb begin
    y_ext_s = $signed({4'd0, y2_r});
    sr_s    = y_ext_s + pr_r + 20'sd128;
    sg_s    = y_ext_s - pgb_r - pgr_r + 20'sd128;
    sb_s    = y_ext_s + pb_r + 20'sd128;
    rgb_s   = {clamp8(sr_s), clamp8(sg_s), clamp8(sb_s)};
  end

  // Stage 3 output register; holds steady while the consumer stalls.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= 24'h0;
    end else if (!stall_s) begin
      out_valid <= v2_r;
      if (v2_r) begin
        out_data <= rgb_s;
      end
    end
  end

endmodule

// File: tb/tb_ycbcr_to_rgb.sv
// Self-checking bench for ycbcr_to_rgb: directed vectors plus a queue-based
// scoreboard fed by a real-number-free integer colour model.
module tb_ycbcr_to_rgb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [23:0] in_data = 24'h0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [23:0] out_data;

  int tests = 0;
  int fails = 0;
  int n_out = 0;
  logic [23:0] exp_q[$];
  logic        hold_r = 1'b0;
  logic [23:0] held_data = 24'h0;

  always #5 clk = ~clk;

  ycbcr_to_rgb dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
  );

  function automatic int floor_div256(input int a);
    if (a >= 0) return a / 256;
    return -((-a + 255) / 256);
  endfunction

  function automatic int sat(input int v);
    if (v < 0) return 0;
    if (v > 255) return 255;
    return v;
  endfunction

  // JFIF inverse colour transform with Q8 coefficients, round-half-up then floor.
  function automatic logic [23:0] model(input logic [23:0] d);
    int y, cb, cr, r, g, b;
    y  = int'(d[23:16]);
    cb = int'(d[15:8]) - 128;
    cr = int'(d[7:0]) - 128;
    r  = sat(floor_div256(y * 256 + 359 * cr + 128));
    g  = sat(floor_div256(y * 256 - 88 * cb - 183 * cr + 128));
    b  = sat(floor_div256(y * 256 + 454 * cb + 128));
    return {r[7:0], g[7:0], b[7:0]};
  endfunction

  task automatic check(input string name, input logic [23:0] act, input logic [23:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard, stall-hold and ready-rule monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (hold_r) begin
      check("hold_valid", {23'd0, out_valid}, 24'd1);
      check("hold_data", out_data, held_data);
    end
    check("in_ready_rule", {23'd0, in_ready}, {23'd0, ~(out_valid & ~out_ready)});
    if (out_valid && out_ready) begin
      n_out++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_output: got %h expected none at %0t", out_data, $time);
      end else begin
        check("stream", out_data, exp_q.pop_front());
      end
    end
    hold_r    <= out_valid & ~out_ready & ~rst;
    held_data <= out_data;
    if (rst) exp_q.delete();
    else if (in_valid && in_ready) exp_q.push_back(model(in_data));
  end

  task automatic send_one(input string name, input logic [23:0] v, input logic [23:0] exp);
    out_ready = 1'b1;
    in_data   = v;
    in_valid  = 1'b1;
    #1;
    check({name, "_in_ready"}, {23'd0, in_ready}, 24'd1);
    tick();
    in_valid = 1'b0;
    check({name, "_lat1"}, {23'd0, out_valid}, 24'd0);
    tick();
    check({name, "_lat2"}, {23'd0, out_valid}, 24'd0);
    tick();
    check({name, "_lat3"}, {23'd0, out_valid}, 24'd1);
    check(name, out_data, exp);
    tick();
  endtask

  logic [23:0] bp[6] = '{24'h108080, 24'h2040C0, 24'h30C040, 24'hEB8080, 24'h80FF00, 24'h4000FF};
  logic [23:0] mix[8] = '{24'h51505A, 24'h9030E0, 24'h00FF00, 24'hFF0000, 24'h7F7F7F, 24'hC8A050, 24'h22DD11, 24'hAA55AA};

  initial begin
    int idx, hold, start;
    logic acc;

    // Model pinned to hand-computed values.
    check("model_grey", model(24'h808080), 24'h808080);
    check("model_red", model(24'h4C55FF), 24'hFE0000);
    check("model_dark_red", model(24'h0080FF), 24'hB20000);
    check("model_white", model(24'hFFFFFF), 24'hFF79FF);

    tick();
    tick();
    rst = 1'b0;
    #1;
    check("rst_out_valid", {23'd0, out_valid}, 24'd0);
    check("rst_out_data", out_data, 24'h0);
    check("rst_in_ready", {23'd0, in_ready}, 24'd1);
    out_ready = 1'b0;
    #1;
    check("empty_no_stall", {23'd0, in_ready}, 24'd1);
    tick();

    send_one("grey", 24'h808080, 24'h808080);
    send_one("sat_red", 24'h4C55FF, 24'hFE0000);
    send_one("dark_red", 24'h0080FF, 24'hB20000);
    send_one("white", 24'hFFFFFF, 24'hFF79FF);

    // Back-pressure: 6 back-to-back samples, consumer stalls 5 cycles.
    idx = 0; hold = 0; start = n_out;
    for (int c = 0; c < 40; c++) begin
      if (out_valid && hold < 5) begin
        out_ready = 1'b0;
        hold++;
      end else begin
        out_ready = 1'b1;
      end
      in_valid = (idx < 6);
      if (idx < 6) in_data = bp[idx];
      #1;
      if (!out_ready) check("bp_in_ready", {23'd0, in_ready}, 24'd0);
      acc = in_valid & in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    check("bp_accepted", idx[23:0], 24'd6);
    check("bp_hold_cycles", hold[23:0], 24'd5);
    check("bp_out_count", 24'(n_out - start), 24'd6);
    check("bp_queue_empty", 24'(exp_q.size()), 24'd0);

    // Mixed stream with an irregular ready pattern.
    idx = 0; start = n_out;
    for (int c = 0; c < 60; c++) begin
      out_ready = (c % 3 != 1);
      in_valid  = (idx < 8) && (c % 4 != 2);
      if (idx < 8) in_data = mix[idx];
      #1;
      acc = in_valid & in_ready;
      tick();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("mix_out_count", 24'(n_out - start), 24'd8);
    check("mix_queue_empty", 24'(exp_q.size()), 24'd0);

    // Reset with three samples in flight.
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = bp[k];
      tick();
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    rst       = 1'b1;
    start     = n_out;
    tick();
    rst       = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mid_rst_out_valid", {23'd0, out_valid}, 24'd0);
    check("mid_rst_out_data", out_data, 24'h0);
    check("mid_rst_in_ready", {23'd0, in_ready}, 24'd1);
    for (int c = 0; c < 10; c++) begin
      tick();
      check("no_stale_valid", {23'd0, out_valid}, 24'd0);
    end
    check("no_stale_count", 24'(n_out - start), 24'd0);
    send_one("after_rst", 24'h4C55FF, 24'hFE0000);
    tick();
    check("final_queue_empty", 24'(exp_q.size()), 24'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
